dual_adc_capture_ctrl: RTL and testbench
========================================

// Module: dual_adc_capture_ctrl
// PURPOSE
//  Trigger-driven capture sequencer for the two 14-bit ADC sample buses.
//  - Arms under software control and starts a frame on a trigger rising edge.
//  - Packs sample pairs into 32-bit words and writes one frame per channel into FIFO 0 / FIFO 1.
//  - Write ports are Avalon-MM style with waitrequest.
//  - Sits between the ADC inputs and the readout FIFOs; driven by the write-enable, trigger and soft-reset PIOs.
// PARAMETERS
//  LEN_W   16  width of cfg_len (data words per channel per frame)
//  QDEPTH  2   per-channel output queue depth, words (power of 2, >=2)
// PORTS
//  clk_clk          in   1      system clock
//  reset_reset_n    in   1      asynchronous active-low reset
//  soft_rst         in   1      synchronous soft reset, active high
//  arm              in   1      level; 1 = allow triggers
//  trig_in          in   1      trigger level; rising edge starts a frame
//  cfg_len          in   LEN_W  data words per channel per frame; latched at trigger
//  adc0_data        in   14     channel 0 sample, valid every cycle
//  adc1_data        in   14     channel 1 sample, valid every cycle
//  fifo0_writedata  out  32     channel 0 word
//  fifo0_write      out  1      channel 0 write request
//  fifo0_waitrequest in  1      channel 0 stall
//  fifo1_writedata  out  32     channel 1 word
//  fifo1_write      out  1      channel 1 write request
//  fifo1_waitrequest in  1      channel 1 stall
//  busy             out  1      1 in CAPTURE/DRAIN/DONE
//  ovf              out  1      sticky: a word was dropped
//  frame_cnt        out  4      completed frames, wraps 15->0
// BEHAVIOUR
//  Reset (async or soft_rst):
//  - State IDLE; queues emptied; all outputs 0 (writedata 0).
//  - soft_rst takes effect at the next edge; an outstanding write is abandoned.
//  FSM transitions:
//  - IDLE->ARMED when arm=1.
//  - ARMED->IDLE when arm=0.
//  - ARMED->CAPTURE on a trig_in edge (trig_in=1, previous-cycle trig_in=0) with cfg_len!=0.
//    The trigger edge also latches cfg_len.
//  - CAPTURE->DRAIN after cfg_len words have been pushed (or dropped) per channel.
//  - DRAIN->DONE when both queues are empty.
//  - DONE (1 cycle): frame_cnt++, then ->ARMED if arm=1, else ->IDLE.
//  Trigger rules:
//  - Trigger edges outside ARMED are ignored.
//  - cfg_len=0 means the trigger is ignored and the state stays ARMED.
//  - arm=0 during CAPTURE/DRAIN does not abort the frame.
//  Capture timing:
//  - CAPTURE cycle n: the ADC value at that edge is the even sample (n even) or the odd sample (n odd).
//  - On each odd cycle, word {frame_cnt, odd[13:0], even[13:0]} is pushed to both queues simultaneously.
//  - The word is visible on writedata with write=1 on the next cycle.
//  - Both channels stay sample-locked; their handshakes are independent.
//  Queue handshake:
//  - write=1 whenever the queue is non-empty; the head word is on writedata.
//  - The head pops on write & !waitrequest.
//  - writedata/write are held stable while waitrequest=1.
//  - Push while full with no same-cycle pop: the word is dropped, ovf<=1, and it still counts toward cfg_len.
//  - Push and pop in the same cycle while full is legal and loses no data.
//  - ovf is cleared only by reset or soft_rst.
// CONFIGURATION
//  TIMESTAMP_HDR_EN defined:
//  - A free-running 32-bit cycle counter runs from reset; its value is latched on the accepted trigger edge.
//  - The latched value is pushed as the first word of each channel's frame on CAPTURE cycle 0.
//  - The header is not counted in cfg_len; data words follow as above.
//  TIMESTAMP_HDR_EN undefined:
//  - No counter and no header; frames contain data words only.
// TESTING
//  1. cfg_len=4, waitrequest=0, adc0 ramp 0,1,2.., adc1=0x3FFF-ramp, trigger
//     -> 4 writes per FIFO; fifo0 word0=0x0000_4000|{s1,s0}; busy falls; frame_cnt=1.
//  2. cfg_len=8, fifo0_waitrequest=1 for 10 cycles mid-frame
//     -> fifo0 writedata stable while stalled; ovf=1; fifo0 <8 words; fifo1 exactly 8.
//  3. Trigger with arm=0, then a second trigger during CAPTURE
//     -> exactly one frame produced; first trigger ignored.
//  4. soft_rst on CAPTURE cycle 3
//     -> next cycle: write=0, busy=0, ovf=0, frame_cnt=0, state IDLE.
//  5. 16 frames with cfg_len=1, then trigger with cfg_len=0
//     -> frame_cnt wraps to 0; last trigger yields no writes.
//  6. TIMESTAMP_HDR_EN, trigger accepted with counter=0x0000_0123
//     -> first word on both FIFOs=0x0000_0123, then cfg_len data words.

Source files
------------

// File: rtl/dual_adc_capture_ctrl_if.sv
// Avalon-MM style write port toward one readout FIFO.
// The master drives the word and request; the slave stalls with waitrequest.
interface dual_adc_capture_ctrl_if;
   logic [31:0] writedata;
   logic        write;
   logic        waitrequest;

   modport master (
      output writedata,
      output write,
      input  waitrequest
   );

   modport slave (
      input  writedata,
      input  write,
      output waitrequest
   );
endinterface

// File: rtl/dual_adc_capture_ctrl.sv
// Trigger-driven dual ADC capture sequencer: packs sample pairs into per-channel write queues.
// Optional TIMESTAMP_HDR_EN: prefixes each channel's frame with the trigger's cycle-count stamp.
module dual_adc_capture_ctrl #(
   parameter int LEN_W  = 16,
   parameter int QDEPTH = 2
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   input  logic                    soft_rst,
   input  logic                    arm,
   input  logic                    trig_in,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic [13:0]             adc0_data,
   input  logic [13:0]             adc1_data,
   dual_adc_capture_ctrl_if.master fifo0,
   dual_adc_capture_ctrl_if.master fifo1,
   output logic                    busy,
   output logic                    ovf,
   output logic [3:0]              frame_cnt
);

   localparam int AW = $clog2(QDEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic             trig_q;
   logic             trig_edge;
   logic             start;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] word_cnt;
   logic             phase;
   logic [13:0]      even0;
   logic [13:0]      even1;

   logic [31:0]      q_mem [2][QDEPTH];
   logic [PW-1:0]    wr_ptr [2];
   logic [PW-1:0]    rd_ptr [2];
   logic [1:0]       empty;
   logic [1:0]       full;
   logic [1:0]       stall;
   logic [1:0]       pop;
   logic [1:0]       accept;
   logic [1:0]       drop;
   logic             push;
   logic             cap_push;
   logic [31:0]      word [2];

`ifdef TIMESTAMP_HDR_EN
   logic             hdr_push;
   logic [31:0]      ts_cnt;
   logic [31:0]      ts_q;
`endif

   assign trig_edge = trig_in & ~trig_q;

   always_comb begin
      stall = {fifo1.waitrequest, fifo0.waitrequest};
      for (int c = 0; c < 2; c++) begin
         empty[c]  = (wr_ptr[c] == rd_ptr[c]);
         full[c]   = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                     (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
         pop[c]    = ~empty[c] & ~stall[c];
         // a full queue still accepts when its head leaves this cycle
         accept[c] = push & (~full[c] | pop[c]);
         drop[c]   = push & full[c] & ~pop[c];
      end
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (arm) state_nx = S_ARMED;
         end
         S_ARMED: begin
            if (!arm) begin
               state_nx = S_IDLE;
            end else if (trig_edge && cfg_len != '0) begin
               state_nx = S_CAPTURE;
               start    = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (phase && word_cnt == len_q - LEN_W'(1))
               state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (&empty) state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = arm ? S_ARMED : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cap_push = (state == S_CAPTURE) & phase;
`ifdef TIMESTAMP_HDR_EN
      hdr_push = (state == S_CAPTURE) & ~phase & (word_cnt == '0);
      push     = cap_push | hdr_push;
      word[0]  = hdr_push ? ts_q : {frame_cnt, adc0_data, even0};
      word[1]  = hdr_push ? ts_q : {frame_cnt, adc1_data, even1};
`else
      push     = cap_push;
      word[0]  = {frame_cnt, adc0_data, even0};
      word[1]  = {frame_cnt, adc1_data, even1};
`endif
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state     <= S_IDLE;
         trig_q    <= 1'b0;
         len_q     <= '0;
         word_cnt  <= '0;
         phase     <= 1'b0;
         even0     <= '0;
         even1     <= '0;
         frame_cnt <= '0;
         ovf       <= 1'b0;
      end else if (soft_rst) begin
         state     <= S_IDLE;
         trig_q    <= 1'b0;
         len_q     <= '0;
         word_cnt  <= '0;
         phase     <= 1'b0;
         even0     <= '0;
         even1     <= '0;
         frame_cnt <= '0;
         ovf       <= 1'b0;
      end else begin
         state  <= state_nx;
         trig_q <= trig_in;
         if (start) begin
            len_q    <= cfg_len;
            word_cnt <= '0;
            phase    <= 1'b0;
         end else if (state == S_CAPTURE) begin
            phase <= ~phase;
            if (!phase) begin
               even0 <= adc0_data;
               even1 <= adc1_data;
            end else begin
               word_cnt <= word_cnt + LEN_W'(1);
            end
         end
         if (state == S_DONE) frame_cnt <= frame_cnt + 4'd1;
         if (|drop) ovf <= 1'b1;
      end
   end

`ifdef TIMESTAMP_HDR_EN
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ts_cnt <= '0;
         ts_q   <= '0;
      end else if (soft_rst) begin
         ts_cnt <= '0;
         ts_q   <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (start) ts_q <= ts_cnt;
      end
   end
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else if (soft_rst) begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (accept[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
            if (pop[c])    rd_ptr[c] <= rd_ptr[c] + PW'(1);
         end
      end
   end

   // storage needs no reset: emptiness is tracked by the pointers
   always_ff @(posedge clk_clk) begin
      for (int c = 0; c < 2; c++) begin
         if (accept[c]) q_mem[c][wr_ptr[c][AW-1:0]] <= word[c];
      end
   end

   assign fifo0.write     = ~empty[0];
   assign fifo1.write     = ~empty[1];
   assign fifo0.writedata = empty[0] ? '0 : q_mem[0][rd_ptr[0][AW-1:0]];
   assign fifo1.writedata = empty[1] ? '0 : q_mem[1][rd_ptr[1][AW-1:0]];

   assign busy = (state == S_CAPTURE) || (state == S_DRAIN) || (state == S_DONE);

endmodule

// File: tb/tb_dual_adc_capture_ctrl.sv
// Bench for dual_adc_capture_ctrl: random frames, queue-occupancy reference model,
// decoupled scoreboard monitor on both write ports.
module tb_dual_adc_capture_ctrl;
   localparam int QD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        soft_rst = 1'b0;
   logic        arm = 1'b0;
   logic        trig = 1'b0;
   logic [15:0] cfg_len = '0;
   logic [13:0] a0 = '0;
   logic [13:0] a1 = '0;
   logic        wr0 = 1'b0;
   logic        wr1 = 1'b0;
   logic        busy;
   logic        ovf;
   logic [3:0]  fcnt;

   dual_adc_capture_ctrl_if f0 ();
   dual_adc_capture_ctrl_if f1 ();

   assign f0.waitrequest = wr0;
   assign f1.waitrequest = wr1;

   dual_adc_capture_ctrl #(.LEN_W(16), .QDEPTH(QD)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .soft_rst      (soft_rst),
      .arm           (arm),
      .trig_in       (trig),
      .cfg_len       (cfg_len),
      .adc0_data     (a0),
      .adc1_data     (a1),
      .fifo0         (f0),
      .fifo1         (f1),
      .busy          (busy),
      .ovf           (ovf),
      .frame_cnt     (fcnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   int          occ0 = 0;
   int          occ1 = 0;
   int          mfc = 0;
   bit          movf = 1'b0;
   int          n0 = 0;
   int          n1 = 0;
   int          wmode = 0;
   int          stall0_left = 0;
   logic        hold0 = 1'b0;
   logic        hold1 = 1'b0;
   logic        prev_sr = 1'b0;
   logic [31:0] held0 = '0;
   logic [31:0] held1 = '0;

`ifdef TIMESTAMP_HDR_EN
   logic [31:0] ts_model;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ts_model <= '0;
      else if (soft_rst) ts_model <= '0;
      else               ts_model <= ts_model + 32'd1;
   end
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // one clock edge: choose stalls, apply queue rules to the model, advance
   task automatic tick(input bit psh, input logic [31:0] w0,
                       input logic [31:0] w1);
      bit p0;
      bit p1;
      case (wmode)
         0: begin
            wr0 = 1'b0;
            wr1 = 1'b0;
         end
         1: begin
            wr0 = ($urandom % 3) == 0;
            wr1 = ($urandom % 3) == 0;
         end
         default: begin
            wr0 = stall0_left > 0;
            if (stall0_left > 0) stall0_left--;
            wr1 = 1'b0;
         end
      endcase
      p0 = occ0 > 0 && !wr0;
      p1 = occ1 > 0 && !wr1;
      if (psh) begin
         if (occ0 == QD && !p0) movf = 1'b1;
         else begin exp0.push_back(w0); occ0++; end
         if (occ1 == QD && !p1) movf = 1'b1;
         else begin exp1.push_back(w1); occ1++; end
      end
      if (p0) occ0--;
      if (p1) occ1--;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         hold0   = 1'b0;
         hold1   = 1'b0;
         prev_sr = 1'b0;
      end else begin
         if (hold0 && !prev_sr) begin
            chk("hold0_write", 32'(f0.write), 32'd1);
            chk("hold0_data", f0.writedata, held0);
         end
         if (hold1 && !prev_sr) begin
            chk("hold1_write", 32'(f1.write), 32'd1);
            chk("hold1_data", f1.writedata, held1);
         end
         if (!soft_rst && f0.write && !f0.waitrequest) begin
            n0++;
            if (exp0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fifo0_unexpected: got %h required no write",
                        f0.writedata);
            end else chk("fifo0_word", f0.writedata, exp0.pop_front());
         end
         if (!soft_rst && f1.write && !f1.waitrequest) begin
            n1++;
            if (exp1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fifo1_unexpected: got %h required no write",
                        f1.writedata);
            end else chk("fifo1_word", f1.writedata, exp1.pop_front());
         end
         hold0   = f0.write && f0.waitrequest;
         held0   = f0.writedata;
         hold1   = f1.write && f1.waitrequest;
         held1   = f1.writedata;
         prev_sr = soft_rst;
      end
   end

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 300) begin
         tick(1'b0, '0, '0);
         k++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy=1 required busy=0", nm);
      end
   endtask

   task automatic run_frame(input int len, input int sr_at,
                            input bit retrig, input bit rnd_arm);
      logic [13:0] ev0;
      logic [13:0] ev1;
      logic [31:0] ts;
      ev0 = '0;
      ev1 = '0;
      ts  = '0;
      arm  = 1'b1;
      trig = 1'b0;
      n0 = 0;
      n1 = 0;
      tick(1'b0, '0, '0);
      tick(1'b0, '0, '0);
      cfg_len = 16'(len);
      trig    = 1'b1;
`ifdef TIMESTAMP_HDR_EN
      ts = ts_model;
`endif
      tick(1'b0, '0, '0);
      trig = 1'b0;
      for (int n = 0; n < 2 * len; n++) begin
         a0      = 14'($urandom);
         a1      = 14'($urandom);
         cfg_len = 16'($urandom);
         if (rnd_arm) arm = 1'($urandom);
         if (retrig) trig = (n == 2);
         if (wmode == 2 && n == 2) stall0_left = 10;
         if (n == sr_at) begin
            soft_rst = 1'b1;
            tick(1'b0, '0, '0);
            soft_rst = 1'b0;
            arm = 1'b0;
            exp0.delete();
            exp1.delete();
            occ0 = 0;
            occ1 = 0;
            mfc  = 0;
            movf = 1'b0;
            chk("srst_write0", 32'(f0.write), 32'd0);
            chk("srst_write1", 32'(f1.write), 32'd0);
            chk("srst_data0", f0.writedata, 32'd0);
            chk("srst_busy", 32'(busy), 32'd0);
            chk("srst_ovf", 32'(ovf), 32'd0);
            chk("srst_fcnt", 32'(fcnt), 32'd0);
            return;
         end
         if (n % 2 == 0) begin
            ev0 = a0;
            ev1 = a1;
`ifdef TIMESTAMP_HDR_EN
            if (n == 0) begin
               tick(1'b1, ts, ts);
               continue;
            end
`endif
            tick(1'b0, '0, '0);
         end else begin
            tick(1'b1, {4'(mfc), a0, ev0}, {4'(mfc), a1, ev1});
         end
      end
      trig = 1'b0;
      wait_idle("frame");
      mfc = (mfc + 1) % 16;
      chk("frame_cnt", 32'(fcnt), 32'(mfc));
      chk("ovf", 32'(ovf), 32'(movf));
      chk("drained0", 32'(exp0.size()), 32'd0);
      chk("drained1", 32'(exp1.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_fcnt", 32'(fcnt), 32'd0);
      chk("rst_write0", 32'(f0.write), 32'd0);
      chk("rst_write1", 32'(f1.write), 32'd0);
      chk("rst_data0", f0.writedata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // trigger while disarmed is ignored
      arm  = 1'b0;
      trig = 1'b1;
      tick(1'b0, '0, '0);
      trig = 1'b0;
      repeat (5) tick(1'b0, '0, '0);
      chk("unarmed_busy", 32'(busy), 32'd0);

      wmode = 0;
      run_frame(4, -1, 1'b0, 1'b0);

      wmode = 2;
      run_frame(8, -1, 1'b0, 1'b0);
      chk("stall_fifo1_words", 32'(n1), 32'd8);
      chk("stall_fifo0_dropped", 32'(n0 < 8), 32'd1);
      chk("stall_ovf", 32'(ovf), 32'd1);

      wmode = 1;
      run_frame(5, -1, 1'b1, 1'b0);
      run_frame(6, 3, 1'b0, 1'b0);

      // zero length trigger leaves the block armed and silent
      arm = 1'b1;
      tick(1'b0, '0, '0);
      tick(1'b0, '0, '0);
      cfg_len = '0;
      trig = 1'b1;
      tick(1'b0, '0, '0);
      trig = 1'b0;
      repeat (6) tick(1'b0, '0, '0);
      chk("zero_len_busy", 32'(busy), 32'd0);
      chk("zero_len_fcnt", 32'(fcnt), 32'(mfc));

      repeat (16) run_frame(1, -1, 1'b0, 1'b0);
      chk("wrap_fcnt", 32'(fcnt), 32'd0);

      repeat (10) run_frame($urandom_range(1, 12), -1, 1'($urandom), 1'b1);

      repeat (5) tick(1'b0, '0, '0);
      chk("final_q0", 32'(exp0.size()), 32'd0);
      chk("final_q1", 32'(exp1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
